mem_stage_access: RTL and testbench
===================================

Name: mem_stage_access

Overview:
- MEM-stage consumer of the control word produced in ID: takes the MEM control fields (mem_read, mem_write, funct3) plus the EX-computed address and store data, and drives the data-memory/cache request interface.
- Holds the pipeline stalled until the memory responds.
- Performs byte-lane alignment for stores and sign/zero extension for loads before the result goes to WB.

Parameters:
- XLEN, 32, datapath and address width.
- MBE_W, 4, byte-enable width (XLEN/8).

Ports:
- clk  in  1  pipeline clock
- rst  in  1  reset, asynchronous, active-low
- req_valid_i  in  1  MEM-stage control word valid
- mem_read_i  in  1  control word mem_read
- mem_write_i  in  1  control word mem_write
- funct3_i  in  3  load/store width code: 000 b, 001 h, 010 w, 100 bu, 101 hu
- addr_i  in  XLEN  byte address from ALU
- store_data_i  in  XLEN  rs2 value
- dmem_address_o  out  XLEN  word-aligned address ({addr[31:2],2'b00})
- dmem_read_o  out  1  read request
- dmem_write_o  out  1  write request
- dmem_wdata_o  out  XLEN  lane-shifted store data
- dmem_mbe_o  out  MBE_W  byte enables
- dmem_rdata_i  in  XLEN  read data
- dmem_resp_i  in  1  memory response, one-cycle pulse
- stall_o  out  1  freeze IF/ID/EX/MEM registers
- load_data_o  out  XLEN  extended load result, valid when done_o
- done_o  out  1  access complete this cycle
- misalign_o  out  1  misaligned access, dropped

Behaviour:
- FSM states IDLE, BUSY, DONE. Reset: state IDLE; all outputs 0.
- IDLE:
  - A new request is req_valid_i & (mem_read_i | mem_write_i) & aligned.
  - On a new request: stall_o = 1 (combinational); request registers are loaded; next state BUSY.
  - If both mem_read_i and mem_write_i are 1, the access is a read.
- BUSY:
  - dmem_read_o/dmem_write_o, address, wdata and mbe come from registers and are held stable until dmem_resp_i.
  - stall_o = 1.
  - On dmem_resp_i: capture the rdata lane into load_data; next state DONE.
- DONE (exactly one cycle):
  - dmem_read_o = dmem_write_o = 0; stall_o = 0; done_o = 1; load_data_o valid (0 for stores).
  - The pipeline advances at the end of this cycle. Request inputs are ignored. Next state IDLE.
- Minimum latency: request in cycle N, dmem_resp_i in N+1, done_o in N+2.
- Alignment:
  - off = addr_i[1:0].
  - Word access requires off == 0. Half access requires off[0] == 0.
  - A misaligned access issues no memory request and raises no stall: misalign_o = 1 and done_o = 1 for that cycle, load_data_o = 0.
- Store lanes:
  - sb: mbe = 0001 << off.
  - sh: mbe = 0011 << off.
  - sw: mbe = 1111.
  - wdata = store_data_i << (8*off).
- Load extraction: lane = rdata >> (8*off).
  - lb/lh: sign-extend bit 7/15 of the lane.
  - lbu/lhu: zero-extend the lane.
  - lw: full word.
- Unknown funct3 values are treated as word width.
- dmem_resp_i arriving in IDLE or DONE is ignored.
- Reset asserted mid-BUSY: return to IDLE immediately, drop the request, all outputs 0. A late response is then ignored.
- req_valid_i = 0, or neither read nor write set: pass-through with no stall and done_o = 0.

Test Plan:
- lw at addr 0x100, rdata 0xDEADBEEF, resp after 3 cycles -> dmem_read_o held 3 cycles at address 0x100; stall_o = 1 in those 3 cycles plus the request cycle; next cycle done_o = 1, load_data_o = 0xDEADBEEF.
- lb at 0x103, rdata 0x80112233 -> load_data_o = 0xFFFFFF80. Same access as lbu -> 0x00000080.
- sh at 0x202, store_data 0x0000ABCD -> dmem_address_o = 0x200, mbe = 1100, wdata = 0xABCD0000, dmem_write_o = 1 until resp.
- lw at 0x101 -> misalign_o = 1, done_o = 1, no dmem_read_o, stall_o = 0.
- rst low during BUSY of a sw -> outputs 0 asynchronously. A resp pulse after reset is released -> no done_o.
- Back-to-back lw 0x0 then sb 0x5 -> second request accepted only in the cycle after DONE; mbe = 0010.

Source files
------------

// File: rtl/mem_stage_access.sv
// mem_stage_access: MEM-stage data-memory access controller.
// Accepts a load/store control word plus the EX address and store data,
// issues a held request on the dmem interface, stalls the pipeline until
// the one-cycle response, then presents the sign/zero-extended load result
// for exactly one cycle (DONE). Misaligned accesses are dropped on the spot.
// Ports:
//   clk, rst                  clock, asynchronous active-low reset
//   req_valid_i, mem_read_i, mem_write_i, funct3_i, addr_i, store_data_i
//                             MEM control word and operands
//   dmem_address_o, dmem_read_o, dmem_write_o, dmem_wdata_o, dmem_mbe_o
//                             memory request (stable while BUSY)
//   dmem_rdata_i, dmem_resp_i memory read data and response pulse
//   stall_o, load_data_o, done_o, misalign_o
//                             pipeline control and WB result
module mem_stage_access #(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned MBE_W = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               req_valid_i,
   input  logic               mem_read_i,
   input  logic               mem_write_i,
   input  logic [2:0]         funct3_i,
   input  logic [XLEN-1:0]    addr_i,
   input  logic [XLEN-1:0]    store_data_i,
   output logic [XLEN-1:0]    dmem_address_o,
   output logic               dmem_read_o,
   output logic               dmem_write_o,
   output logic [XLEN-1:0]    dmem_wdata_o,
   output logic [MBE_W-1:0]   dmem_mbe_o,
   input  logic [XLEN-1:0]    dmem_rdata_i,
   input  logic               dmem_resp_i,
   output logic               stall_o,
   output logic [XLEN-1:0]    load_data_o,
   output logic               done_o,
   output logic               misalign_o
);

   localparam int unsigned OFF_W = $clog2(MBE_W);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

   state_e             state_q;
   logic [XLEN-1:0]    addr_q;
   logic [XLEN-1:0]    wdata_q;
   logic [MBE_W-1:0]   mbe_q;
   logic               rd_q;
   logic               wr_q;
   logic [OFF_W-1:0]   off_q;
   logic [2:0]         funct3_q;
   logic [XLEN-1:0]    load_q;

   logic [OFF_W-1:0]   off;
   logic               aligned;
   logic               access;
   logic               new_req;
   logic               mis_req;
   logic [MBE_W-1:0]   mbe_d;
   logic [XLEN-1:0]    wdata_d;
   logic [XLEN-1:0]    lane;
   logic [XLEN-1:0]    load_d;
   logic               busy;
   logic               done_st;

   // Request decode: funct3[1] selects word (covers unknown codes), else funct3[0] half, else byte.
   always_comb begin
      off     = addr_i[OFF_W-1:0];
      aligned = 1'b1;
      mbe_d   = MBE_W'(1) << off;
      if (funct3_i[1]) begin
         aligned = (off == '0);
         mbe_d   = '1;
      end else if (funct3_i[0]) begin
         aligned = ~off[0];
         mbe_d   = MBE_W'(3) << off;
      end
      wdata_d = store_data_i << {off, 3'b000};
      access  = req_valid_i & (mem_read_i | mem_write_i);
      // Gated by rst so every output reads 0 while reset is held.
      new_req = rst & (state_q == IDLE) & access & aligned;
      mis_req = rst & (state_q == IDLE) & access & ~aligned;
   end

   // Load lane extraction from the live response data.
   always_comb begin
      lane   = dmem_rdata_i >> {off_q, 3'b000};
      load_d = lane;
      if (!funct3_q[1]) begin
         if (funct3_q[0]) begin
            load_d = {{(XLEN-16){lane[15] & ~funct3_q[2]}}, lane[15:0]};
         end else begin
            load_d = {{(XLEN-8){lane[7] & ~funct3_q[2]}}, lane[7:0]};
         end
      end
   end

   // FSM and request registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= IDLE;
         addr_q   <= '0;
         wdata_q  <= '0;
         mbe_q    <= '0;
         rd_q     <= 1'b0;
         wr_q     <= 1'b0;
         off_q    <= '0;
         funct3_q <= '0;
         load_q   <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (new_req) begin
                  state_q  <= BUSY;
                  addr_q   <= {addr_i[XLEN-1:OFF_W], OFF_W'(0)};
                  wdata_q  <= wdata_d;
                  mbe_q    <= mbe_d;
                  // Read wins when both read and write are set.
                  rd_q     <= mem_read_i;
                  wr_q     <= ~mem_read_i;
                  off_q    <= off;
                  funct3_q <= funct3_i;
                  load_q   <= '0;
               end
            end
            BUSY: begin
               if (dmem_resp_i) begin
                  state_q <= DONE;
                  load_q  <= rd_q ? load_d : '0;
               end
            end
            DONE: begin
               state_q <= IDLE;
               rd_q    <= 1'b0;
               wr_q    <= 1'b0;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // Output decode: request fields are visible only while BUSY.
   always_comb begin
      busy           = (state_q == BUSY);
      done_st        = (state_q == DONE);
      dmem_read_o    = busy & rd_q;
      dmem_write_o   = busy & wr_q;
      dmem_address_o = busy ? addr_q  : '0;
      dmem_wdata_o   = busy ? wdata_q : '0;
      dmem_mbe_o     = busy ? mbe_q   : '0;
      stall_o        = busy | new_req;
      done_o         = done_st | mis_req;
      misalign_o     = mis_req;
      load_data_o    = done_st ? load_q : '0;
   end

endmodule

// File: tb/tb_mem_stage_access.sv
// tb_mem_stage_access: directed checks of mem_stage_access with hand-computed expectations.
module tb_mem_stage_access;

   logic        clk;
   logic        rst;
   logic        req_valid_i;
   logic        mem_read_i;
   logic        mem_write_i;
   logic [2:0]  funct3_i;
   logic [31:0] addr_i;
   logic [31:0] store_data_i;
   logic [31:0] dmem_address_o;
   logic        dmem_read_o;
   logic        dmem_write_o;
   logic [31:0] dmem_wdata_o;
   logic [3:0]  dmem_mbe_o;
   logic [31:0] dmem_rdata_i;
   logic        dmem_resp_i;
   logic        stall_o;
   logic [31:0] load_data_o;
   logic        done_o;
   logic        misalign_o;

   int total = 0;
   int bad   = 0;

   mem_stage_access #(.XLEN(32), .MBE_W(4)) dut (
      .clk            (clk),
      .rst            (rst),
      .req_valid_i    (req_valid_i),
      .mem_read_i     (mem_read_i),
      .mem_write_i    (mem_write_i),
      .funct3_i       (funct3_i),
      .addr_i         (addr_i),
      .store_data_i   (store_data_i),
      .dmem_address_o (dmem_address_o),
      .dmem_read_o    (dmem_read_o),
      .dmem_write_o   (dmem_write_o),
      .dmem_wdata_o   (dmem_wdata_o),
      .dmem_mbe_o     (dmem_mbe_o),
      .dmem_rdata_i   (dmem_rdata_i),
      .dmem_resp_i    (dmem_resp_i),
      .stall_o        (stall_o),
      .load_data_o    (load_data_o),
      .done_o         (done_o),
      .misalign_o     (misalign_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic req(input logic v, input logic r, input logic w, input logic [2:0] f3,
                      input logic [31:0] a, input logic [31:0] d);
      req_valid_i  = v;
      mem_read_i   = r;
      mem_write_i  = w;
      funct3_i     = f3;
      addr_i       = a;
      store_data_i = d;
   endtask

   // Minimum-latency load: request, response next cycle, done the cycle after.
   task automatic do_load(input string tag, input logic w, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] rd, input logic [31:0] exp);
      cyc();
      req(1'b1, 1'b1, w, f3, a, 32'h5555_5555);
      #1;
      chk({tag, "_req_stall"}, 32'(stall_o), 32'd1);
      cyc();
      req_valid_i  = 1'b0;
      dmem_resp_i  = 1'b1;
      dmem_rdata_i = rd;
      #1;
      chk({tag, "_busy_read"}, 32'(dmem_read_o), 32'd1);
      chk({tag, "_busy_write"}, 32'(dmem_write_o), 32'd0);
      chk({tag, "_busy_addr"}, dmem_address_o, a & 32'hFFFF_FFFC);
      cyc();
      dmem_resp_i = 1'b0;
      #1;
      chk({tag, "_done"}, 32'(done_o), 32'd1);
      chk({tag, "_load"}, load_data_o, exp);
      chk({tag, "_done_stall"}, 32'(stall_o), 32'd0);
   endtask

   initial begin
      rst          = 1'b0;
      dmem_resp_i  = 1'b0;
      dmem_rdata_i = 32'h0;
      req(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);

      // Reset state.
      cyc();
      cyc();
      chk("rst_stall", 32'(stall_o), 32'd0);
      chk("rst_done", 32'(done_o), 32'd0);
      chk("rst_read", 32'(dmem_read_o), 32'd0);
      chk("rst_addr", dmem_address_o, 32'h0);
      chk("rst_load", load_data_o, 32'h0);
      rst = 1'b1;

      // lw 0x100, response after three BUSY cycles.
      cyc();
      req(1'b1, 1'b1, 1'b0, 3'b010, 32'h100, 32'h0);
      #1;
      chk("lw_req_stall", 32'(stall_o), 32'd1);
      chk("lw_req_read", 32'(dmem_read_o), 32'd0);
      chk("lw_req_done", 32'(done_o), 32'd0);
      cyc();
      req_valid_i = 1'b0;
      #1;
      chk("lw_b1_read", 32'(dmem_read_o), 32'd1);
      chk("lw_b1_addr", dmem_address_o, 32'h100);
      chk("lw_b1_stall", 32'(stall_o), 32'd1);
      cyc();
      chk("lw_b2_read", 32'(dmem_read_o), 32'd1);
      chk("lw_b2_stall", 32'(stall_o), 32'd1);
      cyc();
      dmem_resp_i  = 1'b1;
      dmem_rdata_i = 32'hDEAD_BEEF;
      #1;
      chk("lw_b3_read", 32'(dmem_read_o), 32'd1);
      chk("lw_b3_addr", dmem_address_o, 32'h100);
      cyc();
      dmem_resp_i = 1'b0;
      #1;
      chk("lw_done", 32'(done_o), 32'd1);
      chk("lw_load", load_data_o, 32'hDEAD_BEEF);
      chk("lw_done_stall", 32'(stall_o), 32'd0);
      chk("lw_done_read", 32'(dmem_read_o), 32'd0);
      cyc();
      chk("lw_idle_done", 32'(done_o), 32'd0);
      chk("lw_idle_load", load_data_o, 32'h0);

      // Sign/zero extension and width decode.
      do_load("lb", 1'b0, 3'b000, 32'h103, 32'h8011_2233, 32'hFFFF_FF80);
      do_load("lbu", 1'b0, 3'b100, 32'h103, 32'h8011_2233, 32'h0000_0080);
      do_load("lh", 1'b0, 3'b001, 32'h002, 32'h8001_0000, 32'hFFFF_8001);
      do_load("lhu", 1'b0, 3'b101, 32'h002, 32'h8001_0000, 32'h0000_8001);
      do_load("f3_011", 1'b0, 3'b011, 32'h008, 32'h1122_3344, 32'h1122_3344);
      do_load("rd_wr", 1'b1, 3'b010, 32'h010, 32'h0BAD_F00D, 32'h0BAD_F00D);

      // sh 0x202.
      cyc();
      req(1'b1, 1'b0, 1'b1, 3'b001, 32'h202, 32'h0000_ABCD);
      #1;
      chk("sh_req_stall", 32'(stall_o), 32'd1);
      cyc();
      req_valid_i = 1'b0;
      #1;
      chk("sh_write", 32'(dmem_write_o), 32'd1);
      chk("sh_read", 32'(dmem_read_o), 32'd0);
      chk("sh_addr", dmem_address_o, 32'h200);
      chk("sh_mbe", 32'(dmem_mbe_o), 32'hC);
      chk("sh_wdata", dmem_wdata_o, 32'hABCD_0000);
      cyc();
      dmem_resp_i = 1'b1;
      #1;
      chk("sh_write_held", 32'(dmem_write_o), 32'd1);
      chk("sh_wdata_held", dmem_wdata_o, 32'hABCD_0000);
      cyc();
      dmem_resp_i = 1'b0;
      #1;
      chk("sh_done", 32'(done_o), 32'd1);
      chk("sh_load", load_data_o, 32'h0);
      chk("sh_done_write", 32'(dmem_write_o), 32'd0);

      // Misaligned lw 0x101 and sh 0x203.
      cyc();
      req(1'b1, 1'b1, 1'b0, 3'b010, 32'h101, 32'h0);
      #1;
      chk("mis_lw_flag", 32'(misalign_o), 32'd1);
      chk("mis_lw_done", 32'(done_o), 32'd1);
      chk("mis_lw_stall", 32'(stall_o), 32'd0);
      chk("mis_lw_read", 32'(dmem_read_o), 32'd0);
      chk("mis_lw_load", load_data_o, 32'h0);
      cyc();
      req(1'b1, 1'b0, 1'b1, 3'b001, 32'h203, 32'h1234);
      #1;
      chk("mis_sh_flag", 32'(misalign_o), 32'd1);
      chk("mis_sh_stall", 32'(stall_o), 32'd0);
      chk("mis_sh_write", 32'(dmem_write_o), 32'd0);
      cyc();
      req_valid_i = 1'b0;
      #1;
      chk("mis_after_read", 32'(dmem_read_o), 32'd0);
      chk("mis_after_write", 32'(dmem_write_o), 32'd0);
      chk("mis_after_done", 32'(done_o), 32'd0);
      chk("mis_after_flag", 32'(misalign_o), 32'd0);

      // Valid word with no read/write: pass-through.
      req(1'b1, 1'b0, 1'b0, 3'b010, 32'h40, 32'h0);
      #1;
      chk("nop_stall", 32'(stall_o), 32'd0);
      chk("nop_done", 32'(done_o), 32'd0);
      req_valid_i = 1'b0;

      // Reset asserted mid-BUSY of sw 0x10, then a stray response.
      cyc();
      req(1'b1, 1'b0, 1'b1, 3'b010, 32'h10, 32'h1234_5678);
      cyc();
      req_valid_i = 1'b0;
      #1;
      chk("sw_write", 32'(dmem_write_o), 32'd1);
      chk("sw_mbe", 32'(dmem_mbe_o), 32'hF);
      chk("sw_wdata", dmem_wdata_o, 32'h1234_5678);
      #2;
      rst = 1'b0;
      #1;
      chk("arst_write", 32'(dmem_write_o), 32'd0);
      chk("arst_stall", 32'(stall_o), 32'd0);
      chk("arst_addr", dmem_address_o, 32'h0);
      chk("arst_wdata", dmem_wdata_o, 32'h0);
      chk("arst_mbe", 32'(dmem_mbe_o), 32'h0);
      #2;
      rst = 1'b1;
      cyc();
      dmem_resp_i = 1'b1;
      cyc();
      dmem_resp_i = 1'b0;
      #1;
      chk("late_resp_done", 32'(done_o), 32'd0);
      chk("late_resp_stall", 32'(stall_o), 32'd0);
      chk("late_resp_write", 32'(dmem_write_o), 32'd0);

      // Back-to-back lw 0x0 then sb 0x5 held on the inputs.
      cyc();
      req(1'b1, 1'b1, 1'b0, 3'b010, 32'h0, 32'h0);
      cyc();
      req(1'b1, 1'b0, 1'b1, 3'b000, 32'h5, 32'h0000_00AB);
      dmem_resp_i  = 1'b1;
      dmem_rdata_i = 32'hCAFE_F00D;
      #1;
      chk("b2b_lw_read", 32'(dmem_read_o), 32'd1);
      chk("b2b_lw_addr", dmem_address_o, 32'h0);
      cyc();
      dmem_resp_i = 1'b0;
      #1;
      chk("b2b_lw_done", 32'(done_o), 32'd1);
      chk("b2b_lw_load", load_data_o, 32'hCAFE_F00D);
      chk("b2b_done_stall", 32'(stall_o), 32'd0);
      chk("b2b_done_write", 32'(dmem_write_o), 32'd0);
      cyc();
      chk("b2b_sb_accept", 32'(stall_o), 32'd1);
      chk("b2b_sb_idle_write", 32'(dmem_write_o), 32'd0);
      chk("b2b_sb_idle_done", 32'(done_o), 32'd0);
      cyc();
      req_valid_i = 1'b0;
      #1;
      chk("b2b_sb_write", 32'(dmem_write_o), 32'd1);
      chk("b2b_sb_mbe", 32'(dmem_mbe_o), 32'h2);
      chk("b2b_sb_addr", dmem_address_o, 32'h4);
      chk("b2b_sb_wdata", dmem_wdata_o, 32'h0000_AB00);
      dmem_resp_i = 1'b1;
      cyc();
      dmem_resp_i = 1'b0;
      #1;
      chk("b2b_sb_done", 32'(done_o), 32'd1);
      chk("b2b_sb_load", load_data_o, 32'h0);

      cyc();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
